rtc_bus_ctrl: RTL and testbench
===============================

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter T_SU, default 2, address/data setup cycles before strobe; legal range 1..15.
REQ-002 Parameter T_PW, default 4, strobe low width in cycles; legal range 1..15.
REQ-003 Parameter T_HD, default 2, hold cycles after strobe release; legal range 1..15.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  transaction request; sampled only in IDLE.
REQ-007 rw  in  1  1 = write, 0 = read; latched with start.
REQ-008 addr  in  8  RTC register address; latched with start.
REQ-009 wdata  in  8  write data; latched with start.
REQ-010 bus_in  in  8  RTC multiplexed bus, read side.
REQ-011 bus_out  out  8  RTC multiplexed bus, drive side.
REQ-012 bus_oe  out  1  1 = drive bus_out onto the pad.
REQ-013 cs_n, rd_n, wr_n  out  1 each  active-low chip select, read strobe, write strobe.
REQ-014 ad  out  1  0 = address phase, 1 = data phase.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 rdata  out  8  last read result.

Function
REQ-018 All outputs SHALL be registered; each output is valid in the same cycle as the state that defines it.
REQ-019 States SHALL be: IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, DONE.
REQ-020 IDLE with start=1 SHALL latch rw/addr/wdata and enter A_SU at the next edge; start=0 keeps IDLE.
REQ-021 A_SU, A_PW, A_HD SHALL last T_SU, T_PW, T_HD cycles; cs_n=0, ad=0, bus_oe=1, bus_out=latched addr; wr_n=0 only in A_PW; rd_n=1.
REQ-022 D_SU, D_PW, D_HD SHALL last T_SU, T_PW, T_HD cycles; cs_n=0, ad=1.
REQ-023 Data phase, write: bus_oe=1, bus_out=latched wdata, wr_n=0 only in D_PW, rd_n=1.
REQ-024 Data phase, read: bus_oe=0, rd_n=0 only in D_PW, wr_n=1.
REQ-025 Read: rdata SHALL capture bus_in at the edge that ends the last D_PW cycle; rdata otherwise holds, including across writes.
REQ-026 DONE SHALL last 1 cycle with done=1, cs_n=1, bus_oe=0, strobes high; next state IDLE.
REQ-027 busy SHALL last 2*(T_SU+T_PW+T_HD)+1 cycles per transaction (17 with defaults).
REQ-028 start while busy=1 SHALL be ignored; no queuing.
REQ-029 The earliest next acceptance is start high in the IDLE cycle after DONE, so the minimum start-to-start spacing is 2*(T_SU+T_PW+T_HD)+2 cycles.
REQ-030 Latched rw/addr/wdata SHALL NOT change during a transaction regardless of input activity.
REQ-031 wr_n and rd_n SHALL never be low together; no strobe SHALL be low while cs_n=1.
REQ-032 The phase counter SHALL be 4 bits and reload at each state entry; no wrap within legal parameters.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE: cs_n=1, rd_n=1, wr_n=1, ad=0, bus_oe=0, bus_out=0x00, busy=0, done=0, rdata=0x00, latches=0.
REQ-034 reset SHALL take priority over start and over any in-progress state; an aborted transaction produces no done and no rdata update.

Verification
REQ-035 Reset, then idle 5 cycles -> all outputs at REQ-033 values; start=0 keeps busy=0.
REQ-036 Write addr=0x41, wdata=0x23 (defaults) -> A_SU 2 cycles with bus_out=0x41, ad=0; wr_n low 4 cycles; hold 2 cycles; then bus_out=0x23, ad=1 with the same timing; done on cycle 17 after acceptance; rdata unchanged.
REQ-037 Read addr=0x00, bus_in=0x59 during D_PW -> rd_n low 4 cycles, bus_oe=0 in the data phase, rdata=0x59 from the DONE cycle onward, done pulse once.
REQ-038 start held high continuously plus rw/addr toggling mid-transaction -> acceptances exactly 18 cycles apart; bus_out shows only the values latched at acceptance.
REQ-039 reset asserted in the 2nd D_PW cycle of a write -> next cycle all outputs idle, no done pulse; a new start is accepted immediately after reset deasserts.
REQ-040 T_SU=T_PW=T_HD=1, write -> busy exactly 7 cycles; wr_n low exactly 1 cycle per phase; the checker confirms REQ-031 on every cycle.

Source files
------------

// File: rtl/rtc_bus_ctrl_if.sv
// Bundle of the request, multiplexed-bus and status signals of the RTC bus controller.
// The master side (host) drives requests and bus_in; the slave side is the controller.
interface rtc_bus_ctrl_if;
  logic       i_start;
  logic       i_rw;
  logic [7:0] i_addr;
  logic [7:0] i_wdata;
  logic [7:0] i_bus_in;
  logic [7:0] o_bus_out;
  logic       o_bus_oe;
  logic       o_cs_n;
  logic       o_rd_n;
  logic       o_wr_n;
  logic       o_ad;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_rdata;

  modport master (
    output i_start, i_rw, i_addr, i_wdata, i_bus_in,
    input  o_bus_out, o_bus_oe, o_cs_n, o_rd_n, o_wr_n, o_ad, o_busy, o_done, o_rdata
  );

  modport slave (
    input  i_start, i_rw, i_addr, i_wdata, i_bus_in,
    output o_bus_out, o_bus_oe, o_cs_n, o_rd_n, o_wr_n, o_ad, o_busy, o_done, o_rdata
  );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data RTC bus controller: one address phase and one data phase,
// each made of setup, strobe and hold windows, followed by a single DONE cycle.
module rtc_bus_ctrl #(
  parameter int T_SU = 2,
  parameter int T_PW = 4,
  parameter int T_HD = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rtc_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A_SU = 3'd1,
    A_PW = 3'd2,
    A_HD = 3'd3,
    D_SU = 3'd4,
    D_PW = 3'd5,
    D_HD = 3'd6,
    DONE = 3'd7
  } state_t;

  // Counter reload values: a window of N cycles counts N-1 down to 0.
  localparam logic [3:0] L_SU = 4'(T_SU - 1);
  localparam logic [3:0] L_PW = 4'(T_PW - 1);
  localparam logic [3:0] L_HD = 4'(T_HD - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_rw;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_bus_out;
  logic       r_bus_oe;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic       r_ad;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_rdata;

  state_t     w_next;
  logic       w_phase_end;
  logic       w_accept;
  logic [3:0] w_load;
  logic [3:0] w_cnt_next;
  logic       w_rw;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_addr_ph;
  logic       w_data_ph;
  logic       w_pw;
  logic       w_cap;

  // Next state, counter reload and transaction latch values.
  always_comb begin
    w_phase_end = (r_cnt == 4'd0);
    w_accept    = (r_state == IDLE) && bus.i_start;
    case (r_state)
      IDLE:    w_next = bus.i_start ? A_SU : IDLE;
      A_SU:    w_next = w_phase_end ? A_PW : A_SU;
      A_PW:    w_next = w_phase_end ? A_HD : A_PW;
      A_HD:    w_next = w_phase_end ? D_SU : A_HD;
      D_SU:    w_next = w_phase_end ? D_PW : D_SU;
      D_PW:    w_next = w_phase_end ? D_HD : D_PW;
      D_HD:    w_next = w_phase_end ? DONE : D_HD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    case (w_next)
      A_SU, D_SU: w_load = L_SU;
      A_PW, D_PW: w_load = L_PW;
      A_HD, D_HD: w_load = L_HD;
      default:    w_load = 4'd0;
    endcase
    if ((w_next != r_state) || (r_state == IDLE)) begin
      w_cnt_next = w_load;
    end else begin
      w_cnt_next = r_cnt - 4'd1;
    end
    w_rw    = w_accept ? bus.i_rw    : r_rw;
    w_addr  = w_accept ? bus.i_addr  : r_addr;
    w_wdata = w_accept ? bus.i_wdata : r_wdata;
    w_cap   = (r_state == D_PW) && w_phase_end && !r_rw;
  end

  // Decode of the state being entered, so every output register matches its state.
  always_comb begin
    w_addr_ph = (w_next == A_SU) || (w_next == A_PW) || (w_next == A_HD);
    w_data_ph = (w_next == D_SU) || (w_next == D_PW) || (w_next == D_HD);
    w_pw      = (w_next == A_PW) || (w_next == D_PW);
  end

  // Single state machine register block with registered bus and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_rw      <= 1'b0;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_bus_out <= 8'h00;
      r_bus_oe  <= 1'b0;
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_ad      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= 8'h00;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_rw      <= w_rw;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_bus_out <= w_addr_ph ? w_addr : ((w_data_ph && w_rw) ? w_wdata : 8'h00);
      r_bus_oe  <= w_addr_ph || (w_data_ph && w_rw);
      r_cs_n    <= !(w_addr_ph || w_data_ph);
      // The address strobe uses wr_n; the data strobe follows the direction.
      r_wr_n    <= !(w_pw && (w_addr_ph || w_rw));
      r_rd_n    <= !(w_pw && w_data_ph && !w_rw);
      r_ad      <= w_data_ph;
      r_busy    <= (w_next != IDLE);
      r_done    <= (w_next == DONE);
      r_rdata   <= w_cap ? bus.i_bus_in : r_rdata;
    end
  end

  assign bus.o_bus_out = r_bus_out;
  assign bus.o_bus_oe  = r_bus_oe;
  assign bus.o_cs_n    = r_cs_n;
  assign bus.o_rd_n    = r_rd_n;
  assign bus.o_wr_n    = r_wr_n;
  assign bus.o_ad      = r_ad;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_rdata   = r_rdata;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: a cycle-offset model checks two instances (default and
// minimum timing) every cycle, alongside directed literal expectations.
module tb_rtc_bus_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic armed = 1'b0;

  rtc_bus_ctrl_if ifa ();
  rtc_bus_ctrl_if ifb ();

  rtc_bus_ctrl #(.T_SU(2), .T_PW(4), .T_HD(2)) u_dut_a (.i_clk(clk), .i_reset(reset), .bus(ifa.slave));
  rtc_bus_ctrl #(.T_SU(1), .T_PW(1), .T_HD(1)) u_dut_b (.i_clk(clk), .i_reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  // Model: per instance, k = cycles since acceptance (0 = idle), plus latched values.
  int         tsu[2] = '{2, 1};
  int         tpw[2] = '{4, 1};
  int         thd[2] = '{2, 1};
  int         mk[2]  = '{0, 0};
  logic       mrw[2];
  logic [7:0] maddr[2];
  logic [7:0] mwd[2];
  logic [7:0] mrd[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic upd(input int d, input logic st, input logic rw, input logic [7:0] a,
                     input logic [7:0] w, input logic [7:0] bi);
    int p;
    p = tsu[d] + tpw[d] + thd[d];
    if (reset) begin
      mk[d] = 0; mrw[d] = 1'b0; maddr[d] = 8'h00; mwd[d] = 8'h00; mrd[d] = 8'h00;
    end else if (mk[d] == 0) begin
      if (st) begin
        mk[d] = 1; mrw[d] = rw; maddr[d] = a; mwd[d] = w;
      end
    end else begin
      if (!mrw[d] && (mk[d] == p + tsu[d] + tpw[d])) mrd[d] = bi;
      mk[d] = (mk[d] == 2 * p + 1) ? 0 : mk[d] + 1;
    end
  endtask

  task automatic cmp(input int d, input logic [7:0] bo, input logic oe, input logic cs,
                     input logic rd, input logic wr, input logic ad, input logic busy,
                     input logic done, input logic [7:0] rdt);
    int p, k, j;
    logic in_tx, data, strobe, e_oe;
    logic [7:0] e_out;
    string pf;
    pf = (d == 0) ? "a." : "b.";
    p = tsu[d] + tpw[d] + thd[d];
    k = mk[d];
    in_tx = (k >= 1) && (k <= 2 * p);
    data = (k > p) && (k <= 2 * p);
    j = (k >= 1) ? (k - 1) % p : 0;
    strobe = in_tx && (j >= tsu[d]) && (j < tsu[d] + tpw[d]);
    e_oe = in_tx && (!data || mrw[d]);
    e_out = data ? mwd[d] : maddr[d];
    chk({pf, "busy"}, 32'(busy), 32'(k != 0));
    chk({pf, "done"}, 32'(done), 32'(k == 2 * p + 1));
    chk({pf, "cs_n"}, 32'(cs), 32'(!in_tx));
    chk({pf, "bus_oe"}, 32'(oe), 32'(e_oe));
    chk({pf, "wr_n"}, 32'(wr), 32'(!(strobe && (!data || mrw[d]))));
    chk({pf, "rd_n"}, 32'(rd), 32'(!(strobe && data && !mrw[d])));
    chk({pf, "rdata"}, 32'(rdt), 32'(mrd[d]));
    if (in_tx) chk({pf, "ad"}, 32'(ad), 32'(data));
    if (e_oe) chk({pf, "bus_out"}, 32'(bo), 32'(e_out));
    chk({pf, "strobes_exclusive"}, 32'(!(!rd && !wr)), 32'd1);
    chk({pf, "strobe_without_cs"}, 32'(cs && (!rd || !wr)), 32'd0);
  endtask

  // Single compare process: advance the model at each edge, then check both instances.
  always @(posedge clk) begin
    if (reset) armed <= 1'b1;
    upd(0, ifa.i_start, ifa.i_rw, ifa.i_addr, ifa.i_wdata, ifa.i_bus_in);
    upd(1, ifb.i_start, ifb.i_rw, ifb.i_addr, ifb.i_wdata, ifb.i_bus_in);
    #1;
    if (armed) begin
      cmp(0, ifa.o_bus_out, ifa.o_bus_oe, ifa.o_cs_n, ifa.o_rd_n, ifa.o_wr_n, ifa.o_ad,
          ifa.o_busy, ifa.o_done, ifa.o_rdata);
      cmp(1, ifb.o_bus_out, ifb.o_bus_oe, ifb.o_cs_n, ifb.o_rd_n, ifb.o_wr_n, ifb.o_ad,
          ifb.o_busy, ifb.o_done, ifb.o_rdata);
    end
  end

  initial begin
    int wr_low, wr_first, done_at, done_cnt, rd_low, oe_data, busy_cnt, prev_busy, last_acc;
    ifa.i_start = 1'b0; ifa.i_rw = 1'b0; ifa.i_addr = 8'h00; ifa.i_wdata = 8'h00; ifa.i_bus_in = 8'h00;
    ifb.i_start = 1'b0; ifb.i_rw = 1'b0; ifb.i_addr = 8'h00; ifb.i_wdata = 8'h00; ifb.i_bus_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cs_n", 32'(ifa.o_cs_n), 32'd1);
    chk("rst_rd_wr", 32'({ifa.o_rd_n, ifa.o_wr_n}), 32'd3);
    chk("rst_ad_oe", 32'({ifa.o_ad, ifa.o_bus_oe}), 32'd0);
    chk("rst_bus_out", 32'(ifa.o_bus_out), 32'h00);
    chk("rst_busy_done", 32'({ifa.o_busy, ifa.o_done}), 32'd0);
    chk("rst_rdata", 32'(ifa.o_rdata), 32'h00);

    // Directed write 0x41 <- 0x23.
    ifa.i_start = 1'b1; ifa.i_rw = 1'b1; ifa.i_addr = 8'h41; ifa.i_wdata = 8'h23;
    wr_low = 0; wr_first = 0; done_at = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      ifa.i_start = 1'b0; ifa.i_addr = 8'hFF; ifa.i_wdata = 8'hEE;
      if (c == 1) begin
        chk("w_c1_bus_out", 32'(ifa.o_bus_out), 32'h41);
        chk("w_c1_ad", 32'(ifa.o_ad), 32'd0);
      end
      if (c == 9) begin
        chk("w_c9_bus_out", 32'(ifa.o_bus_out), 32'h23);
        chk("w_c9_ad", 32'(ifa.o_ad), 32'd1);
      end
      if (!ifa.o_wr_n) begin
        wr_low++;
        if (wr_first == 0) wr_first = c;
      end
      if (ifa.o_done && done_at == 0) done_at = c;
      if (c == 17) chk("w_rdata_held", 32'(ifa.o_rdata), 32'h00);
    end
    chk("w_wr_low_cycles", 32'(wr_low), 32'd8);
    chk("w_first_strobe", 32'(wr_first), 32'd3);
    chk("w_done_cycle", 32'(done_at), 32'd17);

    // Directed read from 0x00, device drives 0x59 while rd_n is low.
    ifa.i_start = 1'b1; ifa.i_rw = 1'b0; ifa.i_addr = 8'h00;
    rd_low = 0; oe_data = 0; done_cnt = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      ifa.i_start = 1'b0;
      ifa.i_bus_in = (!ifa.o_rd_n) ? 8'h59 : 8'($urandom_range(0, 255));
      if (!ifa.o_rd_n) rd_low++;
      if (c >= 9 && c <= 16 && ifa.o_bus_oe) oe_data++;
      if (ifa.o_done) done_cnt++;
      if (c == 17) chk("r_rdata_done", 32'(ifa.o_rdata), 32'h59);
    end
    chk("r_rd_low_cycles", 32'(rd_low), 32'd4);
    chk("r_oe_data_phase", 32'(oe_data), 32'd0);
    chk("r_done_pulses", 32'(done_cnt), 32'd1);

    // start held high with inputs toggling: acceptances every 18 cycles.
    prev_busy = 0; last_acc = 0;
    for (int c = 1; c <= 60; c++) begin
      ifa.i_start = 1'b1; ifa.i_rw = 1'($urandom_range(0, 1));
      ifa.i_addr = 8'($urandom_range(0, 255)); ifa.i_wdata = 8'($urandom_range(0, 255));
      ifa.i_bus_in = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (ifa.o_busy && prev_busy == 0) begin
        if (last_acc != 0) chk("b2b_spacing", 32'(c - last_acc), 32'd18);
        last_acc = c;
      end
      prev_busy = int'(ifa.o_busy);
    end
    ifa.i_start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset during the 2nd data strobe cycle of a write.
    ifa.i_start = 1'b1; ifa.i_rw = 1'b1; ifa.i_addr = 8'h12; ifa.i_wdata = 8'h34;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ifa.i_start = 1'b0;
    end
    chk("abort_in_dpw", 32'({ifa.o_ad, ifa.o_wr_n}), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'({ifa.o_busy, ifa.o_done, ifa.o_cs_n, ifa.o_wr_n, ifa.o_bus_oe}), 32'b00110);
    reset = 1'b0; ifa.i_start = 1'b1; ifa.i_rw = 1'b0; ifa.i_addr = 8'h07;
    @(negedge clk);
    chk("accept_after_reset", 32'(ifa.o_busy), 32'd1);
    ifa.i_start = 1'b0;
    repeat (20) @(negedge clk);

    // Minimum timing instance: single-cycle windows.
    ifb.i_start = 1'b1; ifb.i_rw = 1'b1; ifb.i_addr = 8'hA5; ifb.i_wdata = 8'h5A;
    busy_cnt = 0; wr_low = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      ifb.i_start = 1'b0;
      if (ifb.o_busy) busy_cnt++;
      if (!ifb.o_wr_n) wr_low++;
    end
    chk("min_busy_cycles", 32'(busy_cnt), 32'd7);
    chk("min_wr_low_cycles", 32'(wr_low), 32'd2);

    // Random traffic on both instances with occasional resets.
    for (int c = 0; c < 2500; c++) begin
      ifa.i_start = ($urandom_range(0, 3) == 0); ifa.i_rw = 1'($urandom_range(0, 1));
      ifa.i_addr = 8'($urandom_range(0, 255)); ifa.i_wdata = 8'($urandom_range(0, 255));
      ifa.i_bus_in = 8'($urandom_range(0, 255));
      ifb.i_start = ($urandom_range(0, 2) == 0); ifb.i_rw = 1'($urandom_range(0, 1));
      ifb.i_addr = 8'($urandom_range(0, 255)); ifb.i_wdata = 8'($urandom_range(0, 255));
      ifb.i_bus_in = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0; ifa.i_start = 1'b0; ifb.i_start = 1'b0;
    repeat (25) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
